// File: rtl/chrom_fitness_evaluator.sv
// chrom_fitness_evaluator
//   Drives a table of test vectors into an evolved circuit under test (CUT),
//   waits a programmable settle time after each vector, samples the CUT output
//   and accumulates one saturating error sum per output bit, optionally over
//   several repeat passes. Sits between the HPS PIO registers and the CUT.
//
// Ports:
//   iClock, iReset_n         clock, asynchronous active-low reset
//   iInputSequence           NUM_VECTORS packed test vectors (vector k at k*IN_WIDTH)
//   iExpectedOutput          expected CUT outputs, same packing
//   iValidOutput             per-bit compare enables, same packing
//   iSettleCycles            wait between applying and sampling (0 acts as 1)
//   iRepeatCount             passes over the vector table (0 acts as 1)
//   iStartProcessing         start request (level, only honoured in IDLE)
//   iDoneProcessingFeedback  HPS has read the results
//   iStall                   freezes FSM, counters and sums
//   iCircuitOutput           CUT output
//   oCircuitInput            vector currently driven into the CUT
//   oReadyToProcess          high only in IDLE
//   oDoneProcessing          high only in DONE
//   oErrorSums               error sum for bit b at b*SUM_WIDTH
//   oState                   current state encoding
module chrom_fitness_evaluator #(
  parameter int NUM_VECTORS  = 16,
  parameter int IN_WIDTH     = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int SUM_WIDTH    = 32,
  parameter int SETTLE_WIDTH = 16,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                             iClock,
  input  logic                             iReset_n,
  input  logic [NUM_VECTORS*IN_WIDTH-1:0]  iInputSequence,
  input  logic [NUM_VECTORS*OUT_WIDTH-1:0] iExpectedOutput,
  input  logic [NUM_VECTORS*OUT_WIDTH-1:0] iValidOutput,
  input  logic [SETTLE_WIDTH-1:0]          iSettleCycles,
  input  logic [REPEAT_WIDTH-1:0]          iRepeatCount,
  input  logic                             iStartProcessing,
  input  logic                             iDoneProcessingFeedback,
  input  logic                             iStall,
  input  logic [OUT_WIDTH-1:0]             iCircuitOutput,
  output logic [IN_WIDTH-1:0]              oCircuitInput,
  output logic                             oReadyToProcess,
  output logic                             oDoneProcessing,
  output logic [OUT_WIDTH*SUM_WIDTH-1:0]   oErrorSums,
  output logic [2:0]                       oState
);

  localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE    = IDX_W'(1);
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_ONE = SETTLE_WIDTH'(1);
  localparam logic [REPEAT_WIDTH-1:0] REP_ONE    = REPEAT_WIDTH'(1);
  localparam logic [SUM_WIDTH-1:0]    SUM_ONE    = SUM_WIDTH'(1);
  localparam logic [SUM_WIDTH-1:0]    SUM_MAX    = {SUM_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_DONE    = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t state_r;
  state_t state_s;

  // Configuration captured at start; the PIO inputs are not looked at again
  // until the next run so the HPS may rewrite them while a run is active.
  logic [IN_WIDTH-1:0]     vec_r [NUM_VECTORS];
  logic [OUT_WIDTH-1:0]    exp_r [NUM_VECTORS];
  logic [OUT_WIDTH-1:0]    val_r [NUM_VECTORS];
  logic [SETTLE_WIDTH-1:0] settle_cfg_r;
  logic [REPEAT_WIDTH-1:0] repeat_cfg_r;

  logic [SETTLE_WIDTH-1:0] settle_cnt_r;
  logic [IDX_W-1:0]        index_r;
  logic [REPEAT_WIDTH-1:0] pass_r;
  logic [IN_WIDTH-1:0]     cin_r;
  logic [SUM_WIDTH-1:0]    sum_r [OUT_WIDTH];

  logic [OUT_WIDTH-1:0]    err_s;
  logic [REPEAT_WIDTH-1:0] rep_last_s;
  logic                    last_vec_s;
  logic                    more_pass_s;

  // Per-bit mismatch of the CUT against the expected value, masked by valid.
  always_comb begin
    err_s       = (iCircuitOutput ^ exp_r[index_r]) & val_r[index_r];
    rep_last_s  = repeat_cfg_r - REP_ONE;
    last_vec_s  = (index_r == LAST_IDX);
    more_pass_s = (pass_r < rep_last_s);
  end

  // Next-state decode; a stall holds the current state in every state.
  always_comb begin
    state_s = state_r;
    if (iStall) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iStartProcessing) state_s = ST_APPLY;
          else                  state_s = ST_IDLE;
        end
        ST_APPLY: state_s = ST_SETTLE;
        ST_SETTLE: begin
          // <= rather than == guards against a zero count ever looping.
          if (settle_cnt_r <= SETTLE_ONE) state_s = ST_SAMPLE;
          else                            state_s = ST_SETTLE;
        end
        ST_SAMPLE: begin
          if (!last_vec_s)      state_s = ST_APPLY;
          else if (more_pass_s) state_s = ST_APPLY;
          else                  state_s = ST_DONE;
        end
        ST_DONE: begin
          if (iDoneProcessingFeedback) state_s = ST_RELEASE;
          else                         state_s = ST_DONE;
        end
        ST_RELEASE: begin
          // Both handshake levels must drop so a held start cannot rerun.
          if (!iStartProcessing && !iDoneProcessingFeedback) state_s = ST_IDLE;
          else                                               state_s = ST_RELEASE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) state_r <= ST_IDLE;
    else           state_r <= state_s;
  end

  // Datapath: configuration capture, vector drive, settle count, accumulation.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int k = 0; k < NUM_VECTORS; k++) begin
        vec_r[k] <= '0;
        exp_r[k] <= '0;
        val_r[k] <= '0;
      end
      for (int b = 0; b < OUT_WIDTH; b++) sum_r[b] <= '0;
      settle_cfg_r <= SETTLE_ONE;
      repeat_cfg_r <= REP_ONE;
      settle_cnt_r <= '0;
      index_r      <= '0;
      pass_r       <= '0;
      cin_r        <= '0;
    end else if (!iStall) begin
      case (state_r)
        ST_IDLE: begin
          if (iStartProcessing) begin
            for (int k = 0; k < NUM_VECTORS; k++) begin
              vec_r[k] <= iInputSequence[k*IN_WIDTH +: IN_WIDTH];
              exp_r[k] <= iExpectedOutput[k*OUT_WIDTH +: OUT_WIDTH];
              val_r[k] <= iValidOutput[k*OUT_WIDTH +: OUT_WIDTH];
            end
            for (int b = 0; b < OUT_WIDTH; b++) sum_r[b] <= '0;
            settle_cfg_r <= (iSettleCycles == '0) ? SETTLE_ONE : iSettleCycles;
            repeat_cfg_r <= (iRepeatCount == '0) ? REP_ONE : iRepeatCount;
            index_r      <= '0;
            pass_r       <= '0;
          end
        end
        ST_APPLY: begin
          cin_r        <= vec_r[index_r];
          settle_cnt_r <= settle_cfg_r;
        end
        ST_SETTLE: begin
          settle_cnt_r <= settle_cnt_r - SETTLE_ONE;
        end
        ST_SAMPLE: begin
          for (int b = 0; b < OUT_WIDTH; b++) begin
            if (err_s[b] && (sum_r[b] != SUM_MAX)) sum_r[b] <= sum_r[b] + SUM_ONE;
          end
          if (!last_vec_s) begin
            index_r <= index_r + IDX_ONE;
          end else if (more_pass_s) begin
            index_r <= '0;
            pass_r  <= pass_r + REP_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar gb = 0; gb < OUT_WIDTH; gb++) begin : g_sums
    assign oErrorSums[gb*SUM_WIDTH +: SUM_WIDTH] = sum_r[gb];
  end

  assign oCircuitInput   = cin_r;
  assign oReadyToProcess = (state_r == ST_IDLE);
  assign oDoneProcessing = (state_r == ST_DONE);
  assign oState          = state_r;

endmodule

// File: tb/tb_chrom_fitness_evaluator.sv
module tb_chrom_fitness_evaluator;

  localparam int NV = 16;

  logic          clk;
  logic          rst_n;
  logic [127:0]  in_seq, exp_seq, val_seq;
  logic [15:0]   settle_in;
  logic [7:0]    rep_in;
  logic          start, fb, stall;
  logic [7:0]    cut_q;
  logic [7:0]    cin_a, cin_b;
  logic          ready_a, ready_b, done_a, done_b;
  logic [255:0]  sums_a;
  logic [31:0]   sums_b;
  logic [2:0]    st_a, st_b;

  logic [7:0]    vec   [NV];
  logic [7:0]    expv  [NV];
  logic [7:0]    valv  [NV];
  longint        msum  [8];
  int            cut_mode;
  int            checks;
  int            errors;

  chrom_fitness_evaluator dut_a (
    .iClock(clk), .iReset_n(rst_n),
    .iInputSequence(in_seq), .iExpectedOutput(exp_seq), .iValidOutput(val_seq),
    .iSettleCycles(settle_in), .iRepeatCount(rep_in),
    .iStartProcessing(start), .iDoneProcessingFeedback(fb), .iStall(stall),
    .iCircuitOutput(cut_q), .oCircuitInput(cin_a),
    .oReadyToProcess(ready_a), .oDoneProcessing(done_a),
    .oErrorSums(sums_a), .oState(st_a)
  );

  chrom_fitness_evaluator #(.SUM_WIDTH(4)) dut_b (
    .iClock(clk), .iReset_n(rst_n),
    .iInputSequence(in_seq), .iExpectedOutput(exp_seq), .iValidOutput(val_seq),
    .iSettleCycles(settle_in), .iRepeatCount(rep_in),
    .iStartProcessing(start), .iDoneProcessingFeedback(fb), .iStall(stall),
    .iCircuitOutput(cut_q), .oCircuitInput(cin_b),
    .oReadyToProcess(ready_b), .oDoneProcessing(done_b),
    .oErrorSums(sums_b), .oState(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CUT: a fixed bit shuffle, or stuck at zero.
  function automatic logic [7:0] cut_fn(input logic [7:0] x);
    if (cut_mode == 1) return 8'h00;
    return {x[3:0], x[7:4]} ^ 8'hA5;
  endfunction

  // CUT with one register of latency, so early sampling would read stale data.
  always @(posedge clk) cut_q <= cut_fn(cin_a);

  task automatic pack_cfg();
    for (int k = 0; k < NV; k++) begin
      in_seq[k*8 +: 8]  = vec[k];
      exp_seq[k*8 +: 8] = expv[k];
      val_seq[k*8 +: 8] = valv[k];
    end
  endtask

  task automatic check_val(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Drive one run to DONE and compare cycle count, handshake and sums.
  task automatic run_case(input string name, input int settle_v, input int rep_v,
                          input bit do_stall, input bit noise, input bit hold_start);
    int n, stalls, stall_left, eff_s, eff_r, want_cycles;
    bit did_settle, did_sample, ready_bad, freeze_bad;
    logic [2:0] prev_st;
    logic [7:0] prev_cin, e;
    longint wa, wb;
    eff_s = (settle_v == 0) ? 1 : settle_v;
    eff_r = (rep_v == 0) ? 1 : rep_v;
    for (int b = 0; b < 8; b++) msum[b] = 0;
    for (int k = 0; k < NV; k++) begin
      e = (cut_fn(vec[k]) ^ expv[k]) & valv[k];
      for (int b = 0; b < 8; b++) if (e[b]) msum[b] += eff_r;
    end
    settle_in = 16'(settle_v);
    rep_in    = 8'(rep_v);
    pack_cfg();
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    if (noise) begin
      for (int i = 0; i < 4; i++) begin
        in_seq[i*32 +: 32]  = $urandom();
        exp_seq[i*32 +: 32] = $urandom();
        val_seq[i*32 +: 32] = $urandom();
      end
      settle_in = 16'($urandom_range(0, 9));
      rep_in    = 8'($urandom_range(0, 9));
    end
    n = 0; stalls = 0; stall_left = 0;
    did_settle = 1'b0; did_sample = 1'b0; ready_bad = 1'b0; freeze_bad = 1'b0;
    while (st_a != 3'd4 && n < 5000) begin
      stall = 1'b0;
      if (do_stall) begin
        if (stall_left > 0) begin
          stall = 1'b1; stall_left--;
        end else if (!did_settle && st_a == 3'd2 && n >= 10) begin
          did_settle = 1'b1; stall = 1'b1; stall_left = 4;
        end else if (did_settle && !did_sample && st_a == 3'd3) begin
          did_sample = 1'b1; stall = 1'b1;
        end
      end
      if (noise) fb = 1'($urandom_range(0, 1));
      prev_st  = st_a;
      prev_cin = cin_a;
      @(posedge clk); #1;
      n++;
      if (stall) begin
        stalls++;
        if (st_a !== prev_st || cin_a !== prev_cin) freeze_bad = 1'b1;
      end
      if (ready_a !== 1'b0 || ready_b !== 1'b0) ready_bad = 1'b1;
    end
    stall = 1'b0;
    fb    = 1'b0;
    want_cycles = eff_r * NV * (eff_s + 2) + stalls;
    check_val({name, " cycles"}, n, want_cycles);
    check_val({name, " ready_low"}, ready_bad, 0);
    check_val({name, " done_a"}, done_a, 1);
    check_val({name, " done_b"}, done_b, 1);
    if (do_stall) begin
      check_val({name, " stall_freeze"}, freeze_bad, 0);
      check_val({name, " stalls_seen"}, stalls, 6);
    end
    for (int b = 0; b < 8; b++) begin
      wa = (msum[b] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : msum[b];
      wb = (msum[b] > 15) ? 15 : msum[b];
      check_val($sformatf("%s sum32[%0d]", name, b), sums_a[b*32 +: 32], wa);
      check_val($sformatf("%s sum4[%0d]", name, b), sums_b[b*4 +: 4], wb);
    end
  endtask

  task automatic release_to_idle(input string name);
    fb = 1'b1;
    @(posedge clk); #1;
    check_val({name, " release"}, st_a, 5);
    fb    = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check_val({name, " idle"}, st_a, 0);
    check_val({name, " ready"}, ready_a, 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; fb = 1'b0; stall = 1'b0;
    settle_in = 16'd1; rep_in = 8'd1;
    in_seq = '0; exp_seq = '0; val_seq = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset state", st_a, 0);
    check_val("reset ready", ready_a, 1);
    check_val("reset done", done_a, 0);
    check_val("reset cin", cin_a, 0);
    check_val("reset sums", (sums_a == '0 && sums_b == '0), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post reset state", st_b, 0);
  endtask

  task automatic test_perfect();
    cut_mode = 0;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom()); expv[k] = cut_fn(vec[k]); valv[k] = 8'($urandom());
    end
    run_case("perfect", 1, 1, 1'b0, 1'b0, 1'b0);
    release_to_idle("perfect");
  endtask

  task automatic test_stuck();
    cut_mode = 1;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom()); expv[k] = 8'hFF; valv[k] = 8'hFF;
    end
    run_case("stuck", 1, 3, 1'b0, 1'b0, 1'b0);
    release_to_idle("stuck");
  endtask

  task automatic test_valid_mask();
    cut_mode = 0;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom()); expv[k] = ~cut_fn(vec[k]); valv[k] = 8'h0F;
    end
    run_case("mask", 2, 1, 1'b0, 1'b0, 1'b0);
    release_to_idle("mask");
  endtask

  task automatic test_saturation();
    cut_mode = 0;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom()); expv[k] = cut_fn(vec[k]) ^ 8'h01; valv[k] = 8'hFF;
    end
    run_case("saturate", 1, 2, 1'b0, 1'b0, 1'b0);
    release_to_idle("saturate");
  endtask

  task automatic test_stall();
    cut_mode = 0;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom()); expv[k] = 8'($urandom()); valv[k] = 8'($urandom());
    end
    run_case("stall", 1, 2, 1'b1, 1'b0, 1'b0);
    release_to_idle("stall");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      cut_mode = 0;
      for (int k = 0; k < NV; k++) begin
        vec[k] = 8'($urandom()); expv[k] = 8'($urandom()); valv[k] = 8'($urandom());
      end
      run_case($sformatf("random%0d", it), $urandom_range(0, 3), $urandom_range(0, 3),
               1'b0, 1'b1, 1'b0);
      release_to_idle($sformatf("random%0d", it));
    end
  endtask

  task automatic test_handshake();
    cut_mode = 0;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom()); expv[k] = 8'($urandom()); valv[k] = 8'hFF;
    end
    run_case("hold", 1, 1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_val("hold done stays", st_a, 4);
    check_val("hold sums stable", sums_a[31:0], msum[0]);
    fb = 1'b1;
    @(posedge clk); #1;
    fb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("hold in release", st_a, 5);
    start = 1'b0;
    @(posedge clk); #1;
    check_val("hold back idle", st_a, 0);
    repeat (4) @(posedge clk);
    #1;
    check_val("hold no rerun", st_a, 0);
  endtask

  task automatic test_reset_mid();
    int n;
    cut_mode = 1;
    for (int k = 0; k < NV; k++) begin
      vec[k] = 8'($urandom() | 1); expv[k] = 8'hFF; valv[k] = 8'hFF;
    end
    settle_in = 16'd3; rep_in = 8'd1;
    pack_cfg();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(st_a == 3'd2 && sums_a[31:0] >= 32'd2) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("midreset reached settle", (n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midreset state", st_a, 0);
    check_val("midreset ready", ready_a, 1);
    check_val("midreset cin", cin_a, 0);
    check_val("midreset sums", (sums_a == '0 && sums_b == '0), 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("midreset idle", st_a, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cut_mode = 0;
    test_reset();
    test_perfect();
    test_stuck();
    test_valid_mask();
    test_saturation();
    test_stall();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chrom_fitness_evaluator.md
Name: chrom_fitness_evaluator

Overview:
- Parametrised successor to the chromosome-processing state machine.
- Drives a configurable number of test vectors into the evolved circuit under test (CUT) and waits a programmable settle time after each one.
- Samples the CUT output, compares it bitwise against the expected output under a valid mask, and accumulates one error sum per output bit, optionally over several repeat passes.
- Sits between the HPS PIO registers (vectors, expected/valid masks, handshake flags, error-sum readback) and the CUT.

Parameters:
- NUM_VECTORS, 16, number of test vectors per pass (>=1).
- IN_WIDTH, 8, CUT input width.
- OUT_WIDTH, 8, CUT output width; one error sum per bit.
- SUM_WIDTH, 32, width of each error sum; saturating.
- SETTLE_WIDTH, 16, width of the settle-cycle count input.
- REPEAT_WIDTH, 8, width of the repeat-count input.

Ports:
- iClock  in  1  system clock.
- iReset_n  in  1  asynchronous active-low reset.
- iInputSequence  in  NUM_VECTORS*IN_WIDTH  test vectors; vector k at [k*IN_WIDTH +: IN_WIDTH].
- iExpectedOutput  in  NUM_VECTORS*OUT_WIDTH  expected CUT outputs, same packing.
- iValidOutput  in  NUM_VECTORS*OUT_WIDTH  per-bit compare enable, same packing.
- iSettleCycles  in  SETTLE_WIDTH  cycles to wait between applying a vector and sampling; 0 is treated as 1.
- iRepeatCount  in  REPEAT_WIDTH  passes over all vectors; 0 is treated as 1.
- iStartProcessing  in  1  start request, level.
- iDoneProcessingFeedback  in  1  HPS has read the results.
- iStall  in  1  freezes the FSM, counters and sums.
- iCircuitOutput  in  OUT_WIDTH  CUT output.
- oCircuitInput  out  IN_WIDTH  vector driven into the CUT.
- oReadyToProcess  out  1  high only in IDLE.
- oDoneProcessing  out  1  high only in DONE.
- oErrorSums  out  OUT_WIDTH*SUM_WIDTH  sum for bit b at [b*SUM_WIDTH +: SUM_WIDTH].
- oState  out  3  current state encoding.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, oCircuitInput=0, all sums=0, oReadyToProcess=1, oDoneProcessing=0, oState=0.
- State encodings: IDLE=0, APPLY=1, SETTLE=2, SAMPLE=3, DONE=4, RELEASE=5.
- IDLE:
  - Configuration inputs (settle, repeat, vectors, expected, valid) are latched into internal registers on the cycle iStartProcessing=1 is seen.
  - Same cycle: sums cleared, vector index=0, pass counter=0, go to APPLY.
  - Inputs are not re-read until the next start.
- APPLY (1 cycle): oCircuitInput <= vector[index]; settle counter <= max(iSettleCycles,1); -> SETTLE.
- SETTLE: counter decrements each cycle; at counter==1 -> SAMPLE. With settle=1, sampling occurs exactly 2 cycles after oCircuitInput changes.
- SAMPLE (1 cycle):
  - err = (iCircuitOutput ^ expected[index]) & valid[index].
  - For each bit b with err[b]=1: sum[b] += 1, saturating at 2^SUM_WIDTH-1 (no wrap).
  - If index<NUM_VECTORS-1: index++ -> APPLY.
  - Else if pass<repeat-1: index=0, pass++ -> APPLY.
  - Else -> DONE.
- DONE:
  - oDoneProcessing=1; oErrorSums stable.
  - iDoneProcessingFeedback=1 -> RELEASE.
- RELEASE: waits for iStartProcessing=0 and iDoneProcessingFeedback=0, then -> IDLE. This prevents re-triggering from a held start level.
- iStall=1:
  - No state, counter, index or sum changes in any state.
  - A SAMPLE cycle under stall is deferred, not dropped; sample and accumulate happen on the first unstalled cycle.
  - oCircuitInput is held.
- iStartProcessing outside IDLE is ignored. iDoneProcessingFeedback outside DONE/RELEASE is ignored.
- oErrorSums are combinationally the sum registers; they update only in SAMPLE and are cleared only on start or reset.
- Cycle count per run = repeat*NUM_VECTORS*(settle+2) from the start cycle to DONE entry.
- Reset mid-run aborts immediately to the reset values; partial sums are lost.

Test Plan:
- Perfect CUT (output=expected), 16 vectors, settle=1, repeat=1:
  - Sums all 0.
  - DONE entered exactly 48 cycles after start.
  - Ready low throughout the run.
- CUT output stuck at 0x00, expected=0xFF for all vectors, valid=0xFF, repeat=3:
  - Every sum equals 48 (3 passes × 16 vectors).
- valid=0x0F for all vectors, output=~expected:
  - Sums for bits 0-3 equal 16.
  - Sums for bits 4-7 equal 0.
- SUM_WIDTH=4, repeat=2, constant mismatch on bit 0 (32 errors): sum[0] saturates at 15.
- iStall held high for 5 cycles during SETTLE and again on a SAMPLE cycle: final sums identical to the unstalled run; total run length extends by exactly the stalled cycles.
- Handshake and reset:
  - Start held high through DONE, then feedback pulsed: FSM stays in RELEASE until both inputs are low, then returns to IDLE without a second run.
  - iReset_n pulsed low mid-SETTLE: outputs return to reset values in the same cycle, asynchronously.
